// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronizes and debounces the coin strobe, queues 5/10 coins in a FIFO
// and presents each on coin_in for a fixed hold window followed by a one-cycle zero gap.
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 3,
   parameter int HOLD_CYCLES = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_detect,
   input  logic [3:0] coin_code,
   output logic [3:0] coin_in,
   output logic       coin_valid,
   output logic       reject,
   output logic       overflow,
   output logic       fifo_full
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;
   state_t state_q, state_d;
   logic det_m_q, det_s_q, stable_q, stable_d;
   logic [3:0] code_m_q, code_s_q;
   logic [3:0] cnt_q, cnt_d, hold_q, hold_d, coin_q, coin_d;
   logic valid_q, valid_d, reject_q, reject_d, overflow_q, overflow_d, full_q, full_d;
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] count_q, count_d;
   logic [3:0] mem_q [FIFO_DEPTH];
   logic mismatch, hit, rise, good, full, empty, push, pop;

   assign full = count_q == CW'(FIFO_DEPTH);
   assign empty = count_q == '0;

   always_comb begin
      state_d = state_q;
      hold_d = hold_q;
      coin_d = coin_q;
      valid_d = valid_q;
      pop = 1'b0;
      case (state_q)
         IDLE, GAP: begin
            state_d = empty ? IDLE : PRESENT;
            if (!empty) begin
               pop = 1'b1;
               coin_d = mem_q[rd_q];
               valid_d = 1'b1;
               hold_d = 4'(HOLD_CYCLES);
            end
         end
         PRESENT: begin
            hold_d = hold_q - 4'd1;
            if (hold_q == 4'd1) begin
               coin_d = 4'd0;
               valid_d = 1'b0;
               state_d = GAP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // stable toggles on the cycle the mismatch count would reach DEBOUNCE_CYCLES
   always_comb begin
      mismatch = det_s_q != stable_q;
      hit = mismatch && cnt_q == 4'(DEBOUNCE_CYCLES - 1);
      cnt_d = (mismatch && !hit) ? cnt_q + 4'd1 : 4'd0;
      stable_d = hit ? ~stable_q : stable_q;
      rise = hit && !stable_q;
      good = code_s_q == 4'd5 || code_s_q == 4'd10;
      push = rise && good && (!full || pop);
      reject_d = rise && !good;
      overflow_d = rise && good && full && !pop;
      wr_d = push ? wr_q + AW'(1) : wr_q;
      rd_d = pop ? rd_q + AW'(1) : rd_q;
      count_d = count_q + CW'(push) - CW'(pop);
      full_d = count_d == CW'(FIFO_DEPTH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         det_m_q <= 1'b0;
         det_s_q <= 1'b0;
         code_m_q <= 4'd0;
         code_s_q <= 4'd0;
         stable_q <= 1'b0;
         cnt_q <= 4'd0;
         hold_q <= 4'd0;
         coin_q <= 4'd0;
         valid_q <= 1'b0;
         reject_q <= 1'b0;
         overflow_q <= 1'b0;
         full_q <= 1'b0;
         wr_q <= '0;
         rd_q <= '0;
         count_q <= '0;
         state_q <= IDLE;
      end else begin
         det_m_q <= coin_detect;
         det_s_q <= det_m_q;
         code_m_q <= coin_code;
         code_s_q <= code_m_q;
         stable_q <= stable_d;
         cnt_q <= cnt_d;
         hold_q <= hold_d;
         coin_q <= coin_d;
         valid_q <= valid_d;
         reject_q <= reject_d;
         overflow_q <= overflow_d;
         full_q <= full_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         count_q <= count_d;
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= code_s_q;
   end

   assign coin_in = coin_q;
   assign coin_valid = valid_q;
   assign reject = reject_q;
   assign overflow = overflow_q;
   assign fifo_full = full_q;
endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage that sits directly upstream of the vending machine controller and produces its `coin_in` stream. It synchronizes and debounces a raw coin-detect strobe from the coin mechanism and classifies the accompanying denomination code. Only valid coins (5, 10) are queued in a small FIFO; invalid ones are rejected. Each queued coin is then presented on `coin_in` for a fixed hold window, with a mandatory zero gap between coins so the controller sees every coin as a distinct event.

## Interface
- `DEBOUNCE_CYCLES`, default 3: consecutive synchronized cycles a level change must persist before it is accepted (range 1–15).
- `HOLD_CYCLES`, default 3: cycles each coin value is held on `coin_in` (range 1–15).
- `FIFO_DEPTH`, default 4: coin queue depth (power of two, 2–16).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `coin_detect`  in  1  raw, bouncy strobe from the coin mechanism; asynchronous to `clk`.
- `coin_code`  in  4  denomination from the mechanism; stable whenever `coin_detect` is high.
- `coin_in`  out  4  coin value to the vending controller; 0 when no coin is presented.
- `coin_valid`  out  1  high exactly while `coin_in` carries a coin.
- `reject`  out  1  one-cycle pulse when a debounced coin carries an invalid code.
- `overflow`  out  1  one-cycle pulse when a valid coin is dropped because the FIFO is full.
- `fifo_full`  out  1  FIFO occupancy equals `FIFO_DEPTH`.

## Operation
- Synchronizer: 2-flop chains on `coin_detect` and on all 4 bits of `coin_code`, giving `det_s` and `code_s`.
- Debouncer: tracks `stable` (reset 0) and a mismatch counter.
  - Each cycle with `det_s != stable`, the counter increments. Any cycle with `det_s == stable` clears it.
  - When the counter reaches `DEBOUNCE_CYCLES`, `stable` toggles and the counter clears.
  - Pulses shorter than `DEBOUNCE_CYCLES` are ignored. A falling transition only re-arms the detector.
- Classify on the edge where `stable` goes 0→1, using `code_s`:
  - `code_s` equal to 5 or 10: push into the FIFO.
  - Any other value, including 0: pulse `reject` and do not push.
  - Valid code with the FIFO full and no pop in the same cycle: pulse `overflow` and drop the coin.
- FIFO: pointers wrap modulo `FIFO_DEPTH`.
  - A push and a pop in the same cycle are both performed and occupancy is unchanged. This also holds when the FIFO is full.
- Output FSM, states IDLE, PRESENT, GAP:
  - IDLE: if the FIFO is non-empty, pop it, load `coin_in` with the popped value, set `coin_valid`=1, load the hold counter with `HOLD_CYCLES`, and go to PRESENT.
  - PRESENT: decrement the hold counter. On the edge where it reaches 0, clear `coin_in` and `coin_valid` and go to GAP.
  - GAP: outputs stay 0 for one cycle. If the FIFO is non-empty, pop it and go directly to PRESENT, as from IDLE. Otherwise go to IDLE.
- Reset, asserted at any time including mid-PRESENT: outputs clear immediately (asynchronous). All outputs reset to 0, the FIFO is emptied, `stable`=0, counters are 0, and the state is IDLE. A coin in flight is lost.

## Timing
- Edge 0 is the first rising edge that samples `coin_detect` high, with bounce-free input.
  - `det_s` is high after edge 1.
  - `stable` rises and the push or `reject` occurs at edge 1+`DEBOUNCE_CYCLES`.
  - From IDLE, `coin_valid` rises at edge 2+`DEBOUNCE_CYCLES`. With defaults, that is edge 5, i.e. visible during the 6th cycle.
- `coin_valid` is high for exactly `HOLD_CYCLES` cycles per coin.
- Back-to-back queued coins are separated by exactly 1 cycle with `coin_in`=0.
- `reject` and `overflow` are each high for exactly one cycle, aligned to edge 1+`DEBOUNCE_CYCLES`.
- `fifo_full` is registered and updates on the same edge as the push or pop that changes occupancy.
- `coin_code` must be held from the rise of `coin_detect` until edge 1+`DEBOUNCE_CYCLES`.

## Test plan
- Reset, then one clean coin with `coin_code`=10 and `coin_detect` held high for 8 cycles → `coin_in`=10 and `coin_valid`=1 rise at edge 5 and stay for 3 cycles, then return to 0. `reject` and `overflow` stay 0.
- Bouncy coin (high 1 cycle, low 1, high 2, low 1, then high 8) with code 5 → exactly one presentation of 5. A separate 2-cycle glitch produces no push and no `reject`.
- `coin_code`=7 with a clean detect → `reject` pulses once at edge 4. `coin_valid` never asserts and the FIFO stays empty.
- Five valid coins (5,10,5,10,5) debounced faster than they drain, `FIFO_DEPTH`=4 → `fifo_full`=1 after the 4th push while none has been popped. The 5th either pushes (if a pop coincides) or pulses `overflow`. Presented values follow FIFO order with a 1-cycle gap between coins.
- Coin arriving while another is being presented, with FIFO full and a push coinciding with a GAP→PRESENT pop → push accepted, no `overflow`, occupancy unchanged.
- `rst` asserted during the 2nd PRESENT cycle of a coin with 2 more queued → `coin_in`=0 and `coin_valid`=0 immediately. After release, no further coin is presented.
